mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Sequencer for the 5x5 signed 8-bit matrix multiplier (200-bit lin/col datapath).
//  Buffers operand A (row-major) and operand B, packs them onto the multiplier buses,
//  waits out the multiplier latency, then captures the 25-byte result and the overflow flag.
//  Sits between the byte-wide host register interface and the multiplier datapath.
// PARAMETERS
//  MUL_LAT  0  register stages inside the multiplier datapath (0 = combinational)
// PORTS
//  clk       in   1    system clock, all state on rising edge
//  rst       in   1    asynchronous reset, ACTIVE-LOW: rst=0 clears all state immediately
//  wr_en     in   1    operand write strobe
//  wr_sel    in   1    0 = matrix A, 1 = matrix B
//  wr_addr   in   5    element index 0..24 = 5*row+col
//  wr_data   in   8    signed element
//  wr_rej    out  1    1-cycle pulse: write rejected (busy or wr_addr>24)
//  start     in   1    begin multiplication (level-sampled)
//  busy      out  1    high in LOAD/RUN
//  done      out  1    high in DONE, until next accepted start
//  ovf       out  1    overflow captured with the result
//  rd_addr   in   5    result element index 0..24
//  rd_data   out  8    result[rd_addr], registered (1-cycle latency), 0 if rd_addr>24
//  mul_lin   out  200  to multiplier: row i of A at [199-40i -:40], element (i,j) at [199-40i-8j -:8]
//  mul_col   out  200  to multiplier: column k of B at [199-40k -:40], element (j,k) at [199-40k-8j -:8]
//  mul_rst   out  1    multiplier reset, active-high, registered
//  mul_res   in   200  multiplier result, element (i,k) at [199-8(5i+k) -:8]
//  mul_ovf   in   1    multiplier overflow
// BEHAVIOUR
//  Reset: state=IDLE; A,B,result stores all 0; mul_lin=mul_col=0; mul_rst=1;
//   busy=done=ovf=wr_rej=0; rd_data=0. Reset mid-operation aborts; no result kept.
//  States: IDLE -> LOAD -> RUN -> DONE -> (start) LOAD.
//   IDLE/DONE: start=1 -> LOAD. Writes accepted here only.
//   LOAD (1 cycle): on exit edge register mul_lin/mul_col from stores, mul_rst<=0,
//    cnt<=MUL_LAT, go RUN.
//   RUN: each edge cnt==0 -> capture mul_res into result store, ovf<=mul_ovf,
//    mul_rst<=1, go DONE; else cnt<=cnt-1.
//   DONE: done=1; results and ovf held until next accepted start (cleared on entry to LOAD).
//  Latency: start sampled at edge T -> done high after edge T+2+MUL_LAT.
//  Write in IDLE/DONE with wr_addr<=24: store byte on that edge. A write on the same edge
//   as start is included in the computation (packing reads stores at LOAD exit).
//  Write while busy, or wr_addr>24: store unchanged, wr_rej=1 for the following cycle.
//  start while busy: ignored, no effect on sequence.
//  start held high across DONE: immediately relaunches (level semantics).
//  cnt width = clog2(MUL_LAT+1), min 1 bit.
//  Readback valid any state; reading during RUN returns previous (cleared) result = 0.
// TESTING
//  A=identity, B[e]=e-12 (e=0..24), start -> done at T+2, rd_data(e)=e-12 for all e, ovf=0.
//  A=all 127, B=all 127, start -> done, ovf=1.
//  MUL_LAT=2, start at T -> busy T..T+3, done rises after edge T+4; mul_rst=0 only in RUN.
//  wr_en during RUN (A[0]=5) -> wr_rej pulse, later A[0] unchanged; wr_addr=25 -> wr_rej.
//  rst=0 asserted mid-RUN -> busy=done=ovf=0 async, stores 0, rd_data(0)=0 next cycle.
//  start pulses during RUN -> single done; rd_addr=31 -> rd_data=0.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Sequencer for the 5x5 signed 8-bit matrix multiplier (200-bit lin/col datapath).
//   Buffers operand matrices A and B written byte-wise by the host, packs them onto the
//   multiplier buses, waits out the multiplier latency, then captures the 25-byte result
//   and the overflow flag for readback.
//
// Parameters
//   MUL_LAT   register stages inside the multiplier datapath (0 = combinational)
//
// Ports
//   clk       system clock, all state on rising edge
//   rst       asynchronous reset, active-low
//   wr_en     operand write strobe
//   wr_sel    0 = matrix A, 1 = matrix B
//   wr_addr   element index 0..24 = 5*row+col
//   wr_data   signed element
//   wr_rej    1-cycle pulse after a rejected write (busy or wr_addr > 24)
//   start     begin multiplication (level-sampled in IDLE/DONE)
//   busy      high in LOAD/RUN
//   done      high in DONE until the next accepted start
//   ovf       overflow captured with the result
//   rd_addr   result element index 0..24
//   rd_data   result[rd_addr], registered, 0 for rd_addr > 24
//   mul_lin   row i of A at [199-40i -:40], element (i,j) at [199-40i-8j -:8]
//   mul_col   column k of B at [199-40k -:40], element (j,k) at [199-40k-8j -:8]
//   mul_rst   multiplier reset, active-high, registered
//   mul_res   multiplier result, element (i,k) at [199-8(5i+k) -:8]
//   mul_ovf   multiplier overflow

module mult_seq_ctrl #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         wr_sel,
  input  logic [4:0]   wr_addr,
  input  logic [7:0]   wr_data,
  output logic         wr_rej,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  input  logic [4:0]   rd_addr,
  output logic [7:0]   rd_data,
  output logic [199:0] mul_lin,
  output logic [199:0] mul_col,
  output logic         mul_rst,
  input  logic [199:0] mul_res,
  input  logic         mul_ovf
);

  localparam int unsigned Dim   = 5;
  localparam int unsigned Elems = Dim * Dim;
  localparam int unsigned CntW  = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [4:0]  MaxAddr = 5'(Elems - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [7:0]        a_q   [Elems];
  logic [7:0]        b_q   [Elems];
  logic [7:0]        res_q [Elems];

  logic [199:0]      mul_lin_q, mul_col_q;
  logic [199:0]      lin_pack, col_pack;
  logic              mul_rst_q;
  logic              ovf_q;
  logic              wr_rej_q;
  logic [7:0]        rd_data_q;

  logic              idle_or_done;
  logic              launch;
  logic              load;
  logic              capture;
  logic              wr_ok;
  logic              wr_bad;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  always_comb begin
    idle_or_done = (state_q == StIdle) || (state_q == StDone);
    launch       = idle_or_done && start;
    load         = (state_q == StLoad);
    capture      = (state_q == StRun) && (cnt_q == '0);
    wr_ok        = wr_en && idle_or_done && (wr_addr <= MaxAddr);
    wr_bad       = wr_en && !wr_ok;
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        state_d = StRun;
        cnt_d   = CntW'(MUL_LAT);
      end
      StRun: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus packing: A goes out row-major, B goes out column-major so each 40-bit
  // lane of mul_col carries one column.
  // ---------------------------------------------------------------------------
  always_comb begin
    lin_pack = '0;
    col_pack = '0;
    for (int r = 0; r < Dim; r++) begin
      for (int c = 0; c < Dim; c++) begin
        lin_pack[199 - 40*r - 8*c -: 8] = a_q[Dim*r + c];
        col_pack[199 - 40*c - 8*r -: 8] = b_q[Dim*r + c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_lin_q <= '0;
      mul_col_q <= '0;
      mul_rst_q <= 1'b1;
      ovf_q     <= 1'b0;
      wr_rej_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_rej_q  <= wr_bad;
      rd_data_q <= (rd_addr <= MaxAddr) ? res_q[rd_addr] : '0;
      // Packing samples the stores on the LOAD exit edge, so a write that
      // landed together with start is already part of the operands.
      if (load) begin
        mul_lin_q <= lin_pack;
        mul_col_q <= col_pack;
        mul_rst_q <= 1'b0;
      end
      if (launch) begin
        ovf_q <= 1'b0;
      end else if (capture) begin
        ovf_q     <= mul_ovf;
        mul_rst_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand stores
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < Elems; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) b_q[wr_addr] <= wr_data;
      else        a_q[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Result store: cleared when a run launches so readback during RUN shows 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < Elems; e++) begin
        res_q[e] <= '0;
      end
    end else if (launch) begin
      for (int e = 0; e < Elems; e++) begin
        res_q[e] <= '0;
      end
    end else if (capture) begin
      for (int e = 0; e < Elems; e++) begin
        res_q[e] <= mul_res[199 - 8*e -: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy    = (state_q == StLoad) || (state_q == StRun);
  assign done    = (state_q == StDone);
  assign ovf     = ovf_q;
  assign wr_rej  = wr_rej_q;
  assign rd_data = rd_data_q;
  assign mul_lin = mul_lin_q;
  assign mul_col = mul_col_q;
  assign mul_rst = mul_rst_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: two instances (MUL_LAT=0 and MUL_LAT=2) share all
// stimulus; each is paired with a behavioural multiplier built from its buses.
// Expected results come from a plain matrix product over the bench's own copies
// of A and B.

module tb_mult_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic         wr_sel = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic         start = 1'b0;
  logic [4:0]   rd_addr = '0;

  logic         d0_wr_rej, d0_busy, d0_done, d0_ovf, d0_mul_rst, d0_movf;
  logic [7:0]   d0_rd_data;
  logic [199:0] d0_lin, d0_col, d0_res;
  logic         d2_wr_rej, d2_busy, d2_done, d2_ovf, d2_mul_rst, d2_movf;
  logic [7:0]   d2_rd_data;
  logic [199:0] d2_lin, d2_col, d2_res;

  int n_vec = 0;
  int n_err = 0;

  int a_m [25];
  int b_m [25];
  int exp_r [25];
  bit exp_ovf;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.MUL_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_rej(d0_wr_rej), .start(start), .busy(d0_busy),
    .done(d0_done), .ovf(d0_ovf), .rd_addr(rd_addr), .rd_data(d0_rd_data),
    .mul_lin(d0_lin), .mul_col(d0_col), .mul_rst(d0_mul_rst),
    .mul_res(d0_res), .mul_ovf(d0_movf)
  );

  mult_seq_ctrl #(.MUL_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_rej(d2_wr_rej), .start(start), .busy(d2_busy),
    .done(d2_done), .ovf(d2_ovf), .rd_addr(rd_addr), .rd_data(d2_rd_data),
    .mul_lin(d2_lin), .mul_col(d2_col), .mul_rst(d2_mul_rst),
    .mul_res(d2_res), .mul_ovf(d2_movf)
  );

  // Behavioural multiplier: unpacks the buses, sums products, wraps to 8 bits,
  // flags any sum outside the signed 8-bit range.
  function automatic logic [200:0] mul_fn(input logic [199:0] lin, input logic [199:0] col);
    logic [199:0] r;
    logic         o;
    int           s, x, y;
    r = '0;
    o = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 5; k++) begin
        s = 0;
        for (int j = 0; j < 5; j++) begin
          x = $signed(lin[199 - 40*i - 8*j -: 8]);
          y = $signed(col[199 - 40*k - 8*j -: 8]);
          s += x * y;
        end
        r[199 - 8*(5*i + k) -: 8] = s[7:0];
        if (s > 127 || s < -128) o = 1'b1;
      end
    end
    return {o, r};
  endfunction

  assign {d0_movf, d0_res} = mul_fn(d0_lin, d0_col);

  logic [200:0] p1 = '0;
  logic [200:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= mul_fn(d2_lin, d2_col);
    p2 <= p1;
  end
  assign {d2_movf, d2_res} = p2;

  // Reference: plain matrix product of the bench's operand copies.
  task automatic compute_ref();
    int s;
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 5; k++) begin
        s = 0;
        for (int j = 0; j < 5; j++) s += a_m[5*i + j] * b_m[5*j + k];
        exp_r[5*i + k] = s;
        if (s > 127 || s < -128) exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [4:0] addr, input logic [7:0] data,
                    input logic exp_rej);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
    chk("wr_rej dut0", d0_wr_rej, exp_rej);
    chk("wr_rej dut2", d2_wr_rej, exp_rej);
    if (!exp_rej) begin
      if (sel) b_m[addr] = $signed(data);
      else     a_m[addr] = $signed(data);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(d0_done && d2_done) && n < 30) begin
      tick();
      n++;
    end
    chk("done within budget", {31'd0, d0_done && d2_done}, 1);
  endtask

  task automatic check_results(input string name);
    logic [7:0] e8;
    wait_done();
    compute_ref();
    chk({name, " ovf dut0"}, d0_ovf, exp_ovf);
    chk({name, " ovf dut2"}, d2_ovf, exp_ovf);
    for (int e = 0; e < 25; e++) begin
      rd_addr = 5'(e);
      tick();
      e8 = exp_r[e][7:0];
      chk($sformatf("%s rd dut0[%0d]", name, e), d0_rd_data, e8);
      chk($sformatf("%s rd dut2[%0d]", name, e), d2_rd_data, e8);
    end
  endtask

  task automatic run_check(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_results(name);
  endtask

  typedef struct {
    logic       sel;
    logic [4:0] addr;
    logic [7:0] data;
    logic       rej;
  } wvec_t;

  wvec_t wtab [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d8;

    for (int e = 0; e < 25; e++) begin
      a_m[e] = 0;
      b_m[e] = 0;
    end

    wtab[0] = '{1'b0, 5'd0,  8'h03, 1'b0};
    wtab[1] = '{1'b1, 5'd24, 8'hFE, 1'b0};
    wtab[2] = '{1'b0, 5'd25, 8'h55, 1'b1};
    wtab[3] = '{1'b1, 5'd31, 8'h77, 1'b1};
    wtab[4] = '{1'b0, 5'd24, 8'h81, 1'b0};
    wtab[5] = '{1'b1, 5'd0,  8'h7F, 1'b0};
    wtab[6] = '{1'b0, 5'd12, 8'hF9, 1'b0};
    wtab[7] = '{1'b1, 5'd26, 8'h11, 1'b1};

    // Reset state, sampled mid-cycle while rst is low.
    #12;
    chk("rst busy",    {d0_busy, d2_busy}, 0);
    chk("rst done",    {d0_done, d2_done}, 0);
    chk("rst ovf",     {d0_ovf, d2_ovf}, 0);
    chk("rst wr_rej",  {d0_wr_rej, d2_wr_rej}, 0);
    chk("rst rd_data", {d0_rd_data, d2_rd_data}, 0);
    chk("rst mul_rst", {d0_mul_rst, d2_mul_rst}, 2'b11);
    chk("rst buses zero", {31'd0, d0_lin == '0 && d0_col == '0 && d2_lin == '0}, 1);
    rst = 1'b1;
    tick();

    // Table of writes in IDLE, including out-of-range addresses.
    for (int v = 0; v < 8; v++) wr(wtab[v].sel, wtab[v].addr, wtab[v].data, wtab[v].rej);
    run_check("table");

    // A = identity, B[e] = e-12.
    for (int e = 0; e < 25; e++) begin
      wr(1'b0, 5'(e), (e % 6 == 0) ? 8'd1 : 8'd0, 1'b0);
      d8 = 8'(e - 12);
      wr(1'b1, 5'(e), d8, 1'b0);
    end
    run_check("ident");
    rd_addr = 5'd31;
    tick();
    chk("rd_addr 31", {d0_rd_data, d2_rd_data}, 0);
    rd_addr = 5'd25;
    tick();
    chk("rd_addr 25", {d0_rd_data, d2_rd_data}, 0);

    // All 127 -> overflow.
    for (int e = 0; e < 25; e++) begin
      wr(1'b0, 5'(e), 8'd127, 1'b0);
      wr(1'b1, 5'(e), 8'd127, 1'b0);
    end
    run_check("sat");

    // Latency, mul_rst window, starts during RUN, level relaunch of dut0.
    start = 1'b1;
    tick();                                     // edge T
    chk("T+0 busy",       {d0_busy, d2_busy}, 2'b11);
    chk("T+0 done clr",   {d0_done, d2_done}, 0);
    chk("T+0 ovf clr",    {d0_ovf, d2_ovf}, 0);
    chk("T+0 mul_rst d2", d2_mul_rst, 1);
    start = 1'b0;
    tick();                                     // T+1
    chk("T+1 busy d2",    d2_busy, 1);
    chk("T+1 mul_rst",    {d0_mul_rst, d2_mul_rst}, 0);
    start = 1'b1;
    tick();                                     // T+2
    chk("T+2 done d0",    d0_done, 1);
    chk("T+2 busy d2",    d2_busy, 1);
    chk("T+2 mul_rst d2", d2_mul_rst, 0);
    tick();                                     // T+3
    chk("T+3 d0 relaunch", {d0_done, d0_busy}, 2'b01);
    chk("T+3 busy d2",    {d2_done, d2_busy}, 2'b01);
    chk("T+3 mul_rst d2", d2_mul_rst, 0);
    start = 1'b0;
    tick();                                     // T+4
    chk("T+4 done d2",    {d2_done, d2_busy}, 2'b10);
    chk("T+4 mul_rst d2", d2_mul_rst, 1);
    chk("T+4 ovf d2",     d2_ovf, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("single done d2", {d2_done, d2_busy}, 2'b10);
    end
    check_results("relaunch");

    // Write while busy is rejected and leaves the store unchanged.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_addr = 5'd0;
    wr_data = 8'd5;
    tick();
    wr_en = 1'b0;
    chk("busy wr_rej",  {d0_wr_rej, d2_wr_rej}, 2'b11);
    tick();
    chk("wr_rej pulse", {d0_wr_rej, d2_wr_rej}, 0);
    check_results("busy_wr");

    // Write on the same edge as start is included.
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_addr = 5'd7;
    wr_data = 8'd2;
    start   = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("start wr no rej", {d0_wr_rej, d2_wr_rej}, 0);
    a_m[7] = 2;
    check_results("wr_with_start");

    // Async reset mid-RUN of dut2 while dut0 holds a result.
    rd_addr = 5'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    d8 = exp_r[0][7:0];
    chk("pre-rst rd d0", d0_rd_data, d8);
    chk("pre-rst busy d2", d2_busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async busy",    {d0_busy, d2_busy}, 0);
    chk("async done",    {d0_done, d2_done}, 0);
    chk("async ovf",     {d0_ovf, d2_ovf}, 0);
    chk("async rd_data", {d0_rd_data, d2_rd_data}, 0);
    chk("async mul_rst", {d0_mul_rst, d2_mul_rst}, 2'b11);
    tick();
    chk("held rst rd_data", {d0_rd_data, d2_rd_data}, 0);
    #3;
    rst = 1'b1;
    for (int e = 0; e < 25; e++) begin
      a_m[e] = 0;
      b_m[e] = 0;
    end
    tick();
    chk("post-rst idle", {d0_busy, d0_done, d2_busy, d2_done}, 0);
    for (int e = 0; e < 25; e++) begin
      d8 = 8'($urandom_range(1, 255));
      wr(1'b1, 5'(e), d8, 1'b0);
    end
    run_check("post_rst");

    // Randomized operand sets, small (no overflow) and full-range values.
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 12; w++) begin
        logic [4:0] ad;
        ad = 5'($urandom_range(0, 31));
        if (it % 2 == 0) d8 = 8'(int'($urandom_range(0, 6)) - 3);
        else             d8 = 8'($urandom_range(0, 255));
        wr(1'($urandom_range(0, 1)), ad, d8, ad > 5'd24);
      end
      run_check($sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
